// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: releases NUM_STAGES reset domains one at a time.
// Each release follows a fixed settle delay. The next domain waits for the
// synchronized ready of the previous one, or for a timeout. A software request
// restarts the whole sequence. timeout_err is sticky until the async reset.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned STAGE_DELAY = 16,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned CNT_BITS    = 8,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned CurW       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sw_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_reset_n,
  output logic                  seq_done,
  output logic                  timeout_err,
  output logic [CurW-1:0]       cur_stage
);

  typedef enum logic [1:0] {StHold, StWaitReady, StDone} state_e;

  localparam logic [CNT_BITS-1:0] DelayLast = CNT_BITS'(STAGE_DELAY - 1);
  localparam logic [CNT_BITS-1:0] TimeoutLast = CNT_BITS'(TIMEOUT - 1);
  localparam logic [CurW-1:0] LastStage = CurW'(NUM_STAGES - 1);

  state_e                state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [CurW-1:0]       cur_q, cur_d;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
  logic                  done_q, done_d;
  logic                  terr_q, terr_d;

  logic [NUM_STAGES-1:0] sync_q [SYNC_STAGES];
  logic [NUM_STAGES-1:0] rdy;
  logic                  rdy_cur;

  // Multi-flop synchronizer chain for the asynchronous ready levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= stage_ready;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rdy     = sync_q[SYNC_STAGES-1];
  assign rdy_cur = rdy[cur_q];

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StHold;
      cnt_q   <= '0;
      cur_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state logic; the software request overrides every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    terr_d  = terr_q;

    case (state_q)
      StHold: begin
        if (cnt_q == DelayLast) begin
          rst_n_d[cur_q] = 1'b1;
          cnt_d          = '0;
          state_d        = StWaitReady;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitReady: begin
        if (rdy_cur || (cnt_q == TimeoutLast)) begin
          // A forced advance is recorded but otherwise behaves like a ready.
          if (!rdy_cur) begin
            terr_d = 1'b1;
          end
          cnt_d = '0;
          if (cur_q == LastStage) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = StHold;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StHold;
      end
    endcase

    if (sw_reset_req) begin
      state_d = StHold;
      cnt_d   = '0;
      cur_d   = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
    end
  end

  assign stage_reset_n = rst_n_q;
  assign seq_done      = done_q;
  assign timeout_err   = terr_q;
  assign cur_stage     = cur_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a timestamp-based reference model is compared
// against the DUT on every falling edge, and directed scenarios pin literal values.
module tb_reset_sequencer;

  localparam int N      = 4;
  localparam int DELAY  = 16;
  localparam int TOUT   = 64;
  localparam int SYNC   = 2;

  logic         clk;
  logic         reset;
  logic         sw_reset_req;
  logic [N-1:0] stage_ready;
  logic [N-1:0] stage_reset_n;
  logic         seq_done;
  logic         timeout_err;
  logic [1:0]   cur_stage;

  int total = 0;
  int bad   = 0;

  reset_sequencer #(
    .NUM_STAGES (N),
    .STAGE_DELAY(DELAY),
    .TIMEOUT    (TOUT),
    .CNT_BITS   (8),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sw_reset_req (sw_reset_req),
    .stage_ready  (stage_ready),
    .stage_reset_n(stage_reset_n),
    .seq_done     (seq_done),
    .timeout_err  (timeout_err),
    .cur_stage    (cur_stage)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: edges since reset release, ready history, phase anchor edge.
  int           edge_n;
  logic [N-1:0] hist[$];
  logic [N-1:0] m_rel;
  logic         m_done;
  logic         m_terr;
  int           m_cur;
  bit           m_hold;
  int           m_anchor;

  function automatic logic [N-1:0] seen(int e);
    // The sequencer acts at edge e on the input sampled SYNC edges earlier.
    if (e - SYNC >= 1) return hist[e-1-SYNC];
    return '0;
  endfunction

  task automatic model_reset();
    edge_n   = 0;
    hist.delete();
    m_rel    = '0;
    m_done   = 1'b0;
    m_terr   = 1'b0;
    m_cur    = 0;
    m_hold   = 1'b1;
    m_anchor = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] r;
    bit           ok;
    bit           to;
    edge_n++;
    hist.push_back(stage_ready);
    if (sw_reset_req) begin
      m_rel    = '0;
      m_done   = 1'b0;
      m_cur    = 0;
      m_hold   = 1'b1;
      m_anchor = edge_n;
    end else if (m_done) begin
      // finished: nothing changes until a restart
    end else if (m_hold) begin
      if (edge_n == m_anchor + DELAY) begin
        m_rel[m_cur] = 1'b1;
        m_hold       = 1'b0;
        m_anchor     = edge_n;
      end
    end else begin
      r  = seen(edge_n);
      ok = r[m_cur];
      to = (edge_n == m_anchor + TOUT);
      if (ok || to) begin
        if (!ok) m_terr = 1'b1;
        if (m_cur == N - 1) begin
          m_done = 1'b1;
        end else begin
          m_cur++;
          m_hold   = 1'b1;
          m_anchor = edge_n;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("model_stage_reset_n", 32'(stage_reset_n), 32'(m_rel));
      chk("model_seq_done", 32'(seq_done), 32'(m_done));
      chk("model_timeout_err", 32'(timeout_err), 32'(m_terr));
      chk("model_cur_stage", 32'(cur_stage), 32'(m_cur));
    end
  end

  // Returns 1 ns after edge n has happened.
  task automatic goto_edge(int n);
    while (edge_n < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(logic [N-1:0] r);
    reset        = 1'b1;
    sw_reset_req = 1'b0;
    stage_ready  = r;
    repeat (3) @(posedge clk);
    #1;
    chk("in_reset_outputs", {26'd0, stage_reset_n, seq_done, timeout_err}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic sw_pulse_after(int n);
    goto_edge(n);
    sw_reset_req = 1'b1;
    goto_edge(n + 1);
    sw_reset_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    sw_reset_req = 1'b0;
    stage_ready  = '1;

    // All ready: releases at 16, 33, 50, 67; done at 68; then software restart.
    do_reset(4'b1111);
    goto_edge(15); chk("s1_rel15", 32'(stage_reset_n), 32'h0);
    goto_edge(16); chk("s1_rel16", 32'(stage_reset_n), 32'h1);
    goto_edge(33); chk("s1_rel33", 32'(stage_reset_n), 32'h3);
    goto_edge(50); chk("s1_rel50", 32'(stage_reset_n), 32'h7);
    goto_edge(67); chk("s1_rel67", 32'(stage_reset_n), 32'hf);
    chk("s1_done67", 32'(seq_done), 32'h0);
    goto_edge(68); chk("s1_done68", 32'(seq_done), 32'h1);
    chk("s1_cur68", 32'(cur_stage), 32'h3);
    chk("s1_terr68", 32'(timeout_err), 32'h0);
    sw_pulse_after(80);
    chk("s4_rel81", 32'(stage_reset_n), 32'h0);
    chk("s4_done81", 32'(seq_done), 32'h0);
    goto_edge(96); chk("s4_rel96", 32'(stage_reset_n), 32'h0);
    goto_edge(97); chk("s4_rel97", 32'(stage_reset_n), 32'h1);

    // Stage 2 never ready: timeout at 114, stage 3 at 130, done at 131.
    do_reset(4'b1011);
    goto_edge(50);  chk("s2_rel50", 32'(stage_reset_n), 32'h7);
    goto_edge(113); chk("s2_terr113", 32'(timeout_err), 32'h0);
    goto_edge(114); chk("s2_terr114", 32'(timeout_err), 32'h1);
    goto_edge(129); chk("s2_rel129", 32'(stage_reset_n), 32'h7);
    goto_edge(130); chk("s2_rel130", 32'(stage_reset_n), 32'hf);
    chk("s2_done130", 32'(seq_done), 32'h0);
    goto_edge(131); chk("s2_done131", 32'(seq_done), 32'h1);
    sw_pulse_after(140);
    chk("s2_sw_rel141", 32'(stage_reset_n), 32'h0);
    chk("s2_sw_terr141", 32'(timeout_err), 32'h1);
    goto_edge(157); chk("s2_sw_rel157", 32'(stage_reset_n), 32'h1);

    // Stage 1 ready late: raised after edge 40, progress resumes at 43.
    do_reset(4'b1101);
    goto_edge(33); chk("s3_rel33", 32'(stage_reset_n), 32'h3);
    goto_edge(40); stage_ready = 4'b1111;
    goto_edge(42); chk("s3_cur42", 32'(cur_stage), 32'h1);
    goto_edge(43); chk("s3_cur43", 32'(cur_stage), 32'h2);
    goto_edge(58); chk("s3_rel58", 32'(stage_reset_n), 32'h3);
    goto_edge(59); chk("s3_rel59", 32'(stage_reset_n), 32'h7);
    chk("s3_terr59", 32'(timeout_err), 32'h0);

    // Software request on the stage 1 release edge wins.
    do_reset(4'b1111);
    sw_pulse_after(32);
    chk("s5_rel33", 32'(stage_reset_n), 32'h0);
    chk("s5_cur33", 32'(cur_stage), 32'h0);
    goto_edge(48); chk("s5_rel48", 32'(stage_reset_n), 32'h0);
    goto_edge(49); chk("s5_rel49", 32'(stage_reset_n), 32'h1);

    // Async reset mid-HOLD clears outputs without a clock edge.
    do_reset(4'b1111);
    goto_edge(45);
    chk("s6_pre_rel45", 32'(stage_reset_n), 32'h3);
    reset = 1'b1;
    #1;
    chk("s6_async_rel", 32'(stage_reset_n), 32'h0);
    chk("s6_async_cur", 32'(cur_stage), 32'h0);
    do_reset(4'b1111);
    goto_edge(16); chk("s6_rel16", 32'(stage_reset_n), 32'h1);
    goto_edge(68); chk("s6_done68", 32'(seq_done), 32'h1);
    chk("s6_rel68", 32'(stage_reset_n), 32'hf);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
